pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU. It drives the enable and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types: load-use, taken branch resolved in MEM, and multi-cycle data-memory access. It also counts stall cycles and halts the pipeline on a memory timeout.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/load_use_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline control path.
package cpu_ctrl_pkg;

    // Hazard sequencer states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    // XZR index: reading or writing it never creates a dependency.
    localparam int unsigned ZERO_REG = 31;

    // Per-stage enable and clear controls fanned out to the stage registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_bubble;
    } pipe_ctrl_t;

    // Free-running pipeline: every stage advances, nothing is cleared.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c              = '0;
        c.pc_en        = 1'b1;
        c.ifid_en      = 1'b1;
        c.idex_en      = 1'b1;
        c.exmem_en     = 1'b1;
        c.memwb_en     = 1'b1;
        return c;
    endfunction

    // Fully frozen pipeline: no stage advances, nothing is cleared.
    function automatic pipe_ctrl_t ctrl_frozen();
        pipe_ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use dependency check between the ID sources and the
// destination of a load sitting in EX.
module load_use_detect #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic [REG_W-1:0] rn_id_i,
    input  logic [REG_W-1:0] rm_id_i,
    input  logic             use_rn_id_i,
    input  logic             use_rm_id_i,
    input  logic             memread_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    output logic             hazard_o
);

    localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

    logic rn_match;
    logic rm_match;

    // A hazard exists only for a real (non-XZR) load destination that an
    // ID source actually reads.
    always_comb begin
        rn_match = use_rn_id_i && (rn_id_i == rd_ex_i);
        rm_match = use_rm_id_i && (rm_id_i == rd_ex_i);
        hazard_o = memread_ex_i && (rd_ex_i != XZR) && (rn_match || rm_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait stalls with timeout, stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = cpu_ctrl_pkg::ZERO_REG,
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rn_id,
    input  logic [REG_W-1:0] rm_id,
    input  logic             use_rn_id,
    input  logic             use_rm_id,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             br_taken_mem,
    input  logic             mem_access_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    import cpu_ctrl_pkg::*;

    localparam int unsigned      WAIT_W    = $clog2(MAX_WAIT + 1);
    // Wait count at which one more waiting cycle hits the timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              lu_hazard;
    logic              dmem_wait;
    logic              timeout;
    pipe_ctrl_t        ctrl;

    load_use_detect #(
        .REG_W   (REG_W),
        .ZERO_REG(ZERO_REG)
    ) u_lu (
        .rn_id_i     (rn_id),
        .rm_id_i     (rm_id),
        .use_rn_id_i (use_rn_id),
        .use_rm_id_i (use_rm_id),
        .memread_ex_i(memread_ex),
        .rd_ex_i     (rd_ex),
        .hazard_o    (lu_hazard)
    );

    assign dmem_wait = mem_access_mem && !dmem_ready;
    assign timeout   = dmem_wait && (wait_cnt_q >= WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Next-state: HALT is sticky; any outstanding wait parks in MEM_WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (timeout)        state_d = ST_HALT;
                else if (dmem_wait) state_d = ST_MEM_WAIT;
                else                state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Output controls by priority: halt, memory wait, branch flush, load-use.
    // While reset is held the pipeline sees free-running controls at once.
    always_comb begin
        ctrl = ctrl_run();
        if (!reset) begin
            ctrl = ctrl_run();
        end else if (state_q == ST_HALT) begin
            ctrl = ctrl_frozen();
        end else if (dmem_wait) begin
            ctrl              = ctrl_frozen();
            ctrl.memwb_en     = 1'b1;
            ctrl.memwb_bubble = 1'b1;
        end else if (br_taken_mem) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (lu_hazard) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    // Counter next values: wait count tracks consecutive waits; stall count
    // saturates instead of wrapping and freezes once halted.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q != ST_HALT) begin
            if (dmem_wait) wait_cnt_d = wait_cnt_q + 1'b1;
            else           wait_cnt_d = '0;
            if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idex_en      = ctrl.idex_en;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign halted       = (state_q == ST_HALT);
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver pushes reference-model expectations, a negedge
// monitor pops and compares against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int MAXW  = 4;
    localparam int CW    = 4;
    localparam int SATV  = (1 << CW) - 1;

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, bubble, halted}
    localparam logic [9:0] P_RUN  = 10'b11111_0000_0;
    localparam logic [9:0] P_WAIT = 10'b00001_0001_0;
    localparam logic [9:0] P_BR   = 10'b11111_1110_0;
    localparam logic [9:0] P_LU   = 10'b00111_0100_0;
    localparam logic [9:0] P_HALT = 10'b00000_0000_1;

    typedef struct packed {
        logic [9:0]    ctl;
        logic [CW-1:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rn_id = '0, rm_id = '0, rd_ex = '0;
    logic use_rn_id = 1'b0, use_rm_id = 1'b0, memread_ex = 1'b0;
    logic br_taken_mem = 1'b0, mem_access_mem = 1'b0, dmem_ready = 1'b1;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, halted;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state.
    bit m_halted = 1'b0;
    int m_waits  = 0;
    int m_stall  = 0;

    pipe_hazard_ctrl #(
        .REG_W(5), .ZERO_REG(31), .MAX_WAIT(MAXW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rn_id(rn_id), .rm_id(rm_id), .use_rn_id(use_rn_id), .use_rm_id(use_rm_id),
        .memread_ex(memread_ex), .rd_ex(rd_ex),
        .br_taken_mem(br_taken_mem), .mem_access_mem(mem_access_mem), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus just after the edge, predict, advance model.
    task automatic step(input logic rst, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic mr, input logic [4:0] rd,
                        input logic br, input logic ma, input logic rdy);
        exp_t e;
        bit wt, lu;
        @(posedge clk);
        #1;
        reset = rst; rn_id = rn; rm_id = rm; use_rn_id = urn; use_rm_id = urm;
        memread_ex = mr; rd_ex = rd; br_taken_mem = br; mem_access_mem = ma; dmem_ready = rdy;
        if (!rst) begin
            m_halted = 1'b0; m_waits = 0; m_stall = 0;
            e.ctl = P_RUN; e.stall = '0;
        end else if (m_halted) begin
            e.ctl = P_HALT; e.stall = CW'(m_stall);
        end else begin
            wt = ma && !rdy;
            lu = mr && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
            if (wt)      e.ctl = P_WAIT;
            else if (br) e.ctl = P_BR;
            else if (lu) e.ctl = P_LU;
            else         e.ctl = P_RUN;
            e.stall = CW'(m_stall);
            if (!e.ctl[9] && m_stall < SATV) m_stall++;
            if (wt) begin
                m_waits++;
                if (m_waits == MAXW) m_halted = 1'b1;
            end else begin
                m_waits = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rst_cycle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd3;
            1: return 5'd5;
            2: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Monitor: compare every presented cycle against the next expectation.
    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_bubble, halted};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.stall) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.stall);
                end
            end
        end
    end

    initial begin
        int budget;
        rst_cycle();
        rst_cycle();
        idle();
        // Load-use on Rn, then clean cycle.
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        idle();
        // Load-use on Rm only.
        step(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        // Match but source unused: no hazard.
        step(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        // XZR destination never stalls.
        step(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
        // Branch beats simultaneous load-use.
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        idle();
        // Three wait cycles with a pending branch, flush on the ready cycle.
        repeat (3) step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        idle();
        // Timeout into HALT, then HALT ignores all inputs.
        rst_cycle();
        repeat (MAXW + 2) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        idle();
        // Reset dropped between edges while in MEM_WAIT.
        rst_cycle();
        repeat (2) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        // Saturation of the stall counter via back-to-back load-use.
        repeat (SATV + 5) step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        idle();
        rst_cycle();
        // Randomized traffic with periodic reset to escape HALT.
        for (int i = 0; i < 500; i++) begin
            logic [4:0] rd;
            rd = pick_reg();
            step((i % 50) != 49, pick_reg(), pick_reg(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 5, rd,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 7);
        end
        idle();
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
